// File: rtl/dac_tx.sv
// dac_tx: 16-bit SPI-style frame transmitter for a 12-bit DAC with a one-entry holding register.
module dac_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] data_in,
    output logic        sclk,
    output logic        sync_n,
    output logic        dato_ser,
    output logic        busy,
    output logic        tx_done,
    output logic        overrun
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic [11:0]   hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic          tx_done_q, tx_done_d;
    logic          overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b1;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            tx_done_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            tx_done_q <= tx_done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        div_d     = div_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        tx_done_d = 1'b0;
        overrun_d = 1'b0;
        if (state_q != IDLE && start) begin
            overrun_d = hold_v_q;
            hold_d    = hold_v_q ? hold_q : data_in;
            hold_v_d  = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (hold_v_q || start) begin
                    state_d  = SHIFT;
                    shift_d  = {4'b0000, hold_v_q ? hold_q : data_in};
                    div_d    = '0;
                    bit_d    = '0;
                    sclk_d   = 1'b1;
                    hold_d   = start ? data_in : hold_q;
                    hold_v_d = hold_v_q && start;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Shift only on the rising edge, after the DAC has sampled on the falling one
                    if (!sclk_q) begin
                        shift_d = {shift_q[14:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            state_d   = GAP;
                            gap_d     = '0;
                            tx_done_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = hold_v_q ? SHIFT : IDLE;
                    if (hold_v_q) begin
                        shift_d  = {4'b0000, hold_q};
                        div_d    = '0;
                        bit_d    = '0;
                        sclk_d   = 1'b1;
                        hold_v_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sclk     = sclk_q;
    assign sync_n   = state_q != SHIFT;
    assign dato_ser = (state_q == SHIFT) && shift_q[15];
    assign busy     = state_q != IDLE;
    assign tx_done  = tx_done_q;
    assign overrun  = overrun_q;
endmodule
